nios2_oci_dct_packer: RTL and testbench
=======================================

// Module: nios2_oci_dct_packer
// PURPOSE
//  Data-trace compressor front end for the Nios II OCI. Packs 2-bit trace codes from the
//  debug core into 30-bit dct_buffer words with a 4-bit dct_count of valid codes.
//  Presents each word over a valid/ready interface to the trace FIFO and the OCI test bench.
//  It is the producer for the dct_buffer/dct_count consumer.
// PARAMETERS
//  CODE_W  2   width of one trace code
//  SLOTS   15  codes per packed word
//  BUF_W   30  CODE_W*SLOTS; derived, never overridden
//  CNT_W   4   width of dct_count; must hold SLOTS
// PORTS
//  clk          in   1      single clock; all logic is rising-edge
//  reset        in   1      asynchronous, active-high reset
//  trace_enable in   1      0: code_valid ignored; packing frozen, output side still drains
//  code_valid   in   1      code presented this cycle (no backpressure to source)
//  code         in   CODE_W trace code
//  flush        in   1      1-cycle pulse: emit partial word
//  dct_buffer   out  BUF_W  packed codes; newest at [CODE_W-1:0]; unused upper slots are 0
//  dct_count    out  CNT_W  number of valid codes in dct_buffer, 1..SLOTS
//  dct_valid    out  1      output word valid
//  dct_ready    in   1      consumer accepts when dct_valid&&dct_ready
//  overflow     out  1      sticky: at least one code was dropped
//  overflow_clr in   1      clears overflow; a same-cycle drop wins and keeps it set
// BEHAVIOUR
//  - Reset (async assert, sync release): accumulator=0, acc_cnt=0, state EMPTY.
//    Outputs: dct_buffer=0, dct_count=0, dct_valid=0, overflow=0.
//  - Two storage stages: accumulator (acc, acc_cnt) and a one-entry output register.
//  - out_free = !dct_valid || dct_ready (same-cycle pop-and-push allowed).
//  - Accept: trace_enable && code_valid && state!=FULL. Effect: acc={acc[BUF_W-CODE_W-1:0],code}, cnt+1.
//  - FSM: EMPTY (cnt=0), FILLING (0<cnt<SLOTS), FULL (cnt=SLOTS, waiting on output).
//  - Completion: an accept that makes cnt==SLOTS moves the word to the output register
//    when out_free. dct_valid then rises next cycle with dct_count=15, and acc goes to EMPTY.
//    If !out_free, go to FULL instead.
//  - FULL: transfer on the first out_free cycle, then go to EMPTY. While in FULL, codes are
//    dropped and overflow is set.
//  - Flush with cnt>0 (cnt counts a same-cycle code, which is included first): transfer the
//    partial word if out_free. The word has the codes in the LSBs and dct_count=cnt.
//    If !out_free, the flush stays pending until transfer; more codes keep packing meanwhile.
//    A pending flush that reaches SLOTS behaves as completion.
//  - Flush with cnt==0 and no same-cycle code: no-op.
//  - Output register holds dct_buffer/dct_count stable while dct_valid && !dct_ready.
//  - Latency: code to dct_valid is 1 cycle when out_free. Sustained throughput is 1 code/cycle.
//  - trace_enable falling mid-word keeps acc; packing resumes when it is reasserted.
// CONFIGURATION
//  NIOS2_OCI_DCT_DROPCNT_EN
//   defined: adds output drop_count[15:0], a saturating count of dropped codes.
//            Cleared by reset and by overflow_clr; a same-cycle drop gives the value 1.
//   undefined: port absent; only the sticky overflow flag is present.
// STRUCTURE
//  - Package nios2_oci_dct_pkg: CODE_W, SLOTS, BUF_W, CNT_W.
//  - Package also holds the state enum {EMPTY, FILLING, FULL} and the code encodings
//    (2'b00 none, 2'b01 load, 2'b10 store, 2'b11 marker).
//  - Sub-module nios2_oci_dct_outreg: one-entry valid/ready register with same-cycle
//    pop/push. The packer holds the accumulator, FSM and overflow logic.
// TESTING
//  1 15 codes 2'b01 back-to-back, dct_ready=1 -> cycle 16: dct_valid=1, dct_count=15,
//    dct_buffer=30'h15555555, acc EMPTY.
//  2 3 codes 11,10,01 then flush, ready=1 -> next cycle: dct_count=3, dct_buffer=30'h39, rest 0.
//  3 dct_ready=0, 30 codes -> word 1 held stable, acc FULL, code 31 dropped, overflow=1.
//    ready=1 -> word 2 follows word 1 without loss.
//  4 flush on the same cycle as the 15th code -> one word, count 15, no extra empty word.
//    flush with cnt=0 -> dct_valid stays 0.
//  5 reset asserted mid-word with dct_valid=1 -> all outputs 0 immediately (async).
//    After release, a new word starts at slot 0.
//  6 DROPCNT_EN: 300 drops -> drop_count=300; overflow_clr with a same-cycle drop -> drop_count=1, overflow=1.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nios2_oci_dct_pkg
// Brief   : Shared widths, FSM states and trace code encodings for the packer.
// Revision: 1.0
// ============================================================================
package nios2_oci_dct_pkg;

    localparam int CODE_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = CODE_W * SLOTS;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } dct_state_t;

    typedef enum logic [CODE_W-1:0] {
        CODE_NONE   = 2'b00,
        CODE_LOAD   = 2'b01,
        CODE_STORE  = 2'b10,
        CODE_MARKER = 2'b11
    } dct_code_t;

endpackage
`default_nettype wire

// File: rtl/nios2_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module  : nios2_oci_dct_outreg
// Brief   : One-entry valid/ready output register; pop and push may share a cycle.
// Revision: 1.0
// ============================================================================
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [BUF_W-1:0] push_buffer,
    input  logic [CNT_W-1:0] push_count,
    output logic             free,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             dct_valid,
    input  logic             dct_ready
);

    assign free = !dct_valid || dct_ready;

    // Data is only loaded on a push, so it stays stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            dct_valid  <= 1'b0;
        end else if (push && free) begin
            dct_buffer <= push_buffer;
            dct_count  <= push_count;
            dct_valid  <= 1'b1;
        end else if (dct_ready) begin
            dct_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module  : nios2_oci_dct_packer
// Brief   : Packs 2-bit trace codes into 30-bit words; accumulator, FSM and
//           overflow tracking in front of a one-entry output register.
//           NIOS2_OCI_DCT_DROPCNT_EN adds a saturating drop_count output.
// Revision: 1.0
// ============================================================================
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_enable,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              flush,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic              overflow,
    input  logic              overflow_clr
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    dct_state_t       r_state;
    logic [BUF_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush_pend;

    logic             w_out_free;
    logic             w_accept;
    logic             w_drop;
    logic [BUF_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_flush_req;
    logic             w_xfer;

    assign w_accept    = trace_enable && code_valid && (r_state != FULL);
    assign w_drop      = trace_enable && code_valid && (r_state == FULL);
    assign w_acc_nxt   = w_accept ? {r_acc[BUF_W-CODE_W-1:0], code} : r_acc;
    assign w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, w_accept};
    assign w_flush_req = flush || r_flush_pend;

    // A same-cycle code is already counted in w_cnt_nxt, so it joins the flushed word.
    assign w_xfer = w_out_free &&
                    ((w_cnt_nxt == CNT_W'(SLOTS)) ||
                     (w_flush_req && (w_cnt_nxt != '0)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= EMPTY;
        end else if (w_xfer) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= EMPTY;
        end else begin
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_flush_pend <= w_flush_req && (w_cnt_nxt != '0);
            if (w_cnt_nxt == '0)
                r_state <= EMPTY;
            else if (w_cnt_nxt == CNT_W'(SLOTS))
                r_state <= FULL;
            else
                r_state <= FILLING;
        end
    end

    // A drop in the clearing cycle wins, keeping the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (w_drop)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (overflow_clr)
            drop_count <= {15'd0, w_drop};
        else if (w_drop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end
`endif

    nios2_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset       (reset),
        .push        (w_xfer),
        .push_buffer (w_acc_nxt),
        .push_count  (w_cnt_nxt),
        .free        (w_out_free),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .dct_valid   (dct_valid),
        .dct_ready   (dct_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios2_oci_dct_packer
// Brief   : Directed bench with a queue-based reference model of the packer.
// Revision: 1.0
// ============================================================================
module tb_nios2_oci_dct_packer;
    import nios2_oci_dct_pkg::*;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              trace_enable = 1'b0;
    logic              code_valid   = 1'b0;
    logic [CODE_W-1:0] code         = '0;
    logic              flush        = 1'b0;
    logic              dct_ready    = 1'b0;
    logic              overflow_clr = 1'b0;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              dct_valid;
    logic              overflow;
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    logic [15:0]       drop_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    nios2_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .trace_enable (trace_enable),
        .code_valid   (code_valid),
        .code         (code),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .dct_valid    (dct_valid),
        .dct_ready    (dct_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: pending codes in a queue, words built by arithmetic packing.
    logic [CODE_W-1:0] mq[$];
    bit                m_pend  = 0;
    bit                m_valid = 0;
    logic [BUF_W-1:0]  m_buf   = '0;
    logic [CNT_W-1:0]  m_cnt   = '0;
    bit                m_ovf   = 0;
    int                m_drops = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pend  = 0;
            m_valid = 0;
            m_buf   = '0;
            m_cnt   = '0;
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            bit               free;
            bit               drop;
            bit               fl;
            logic [BUF_W-1:0] w;
            free = !m_valid || dct_ready;
            drop = trace_enable && code_valid && (mq.size() == SLOTS);
            if (trace_enable && code_valid && mq.size() < SLOTS)
                mq.push_back(code);
            fl = flush || m_pend;
            if (free && (mq.size() == SLOTS || (fl && mq.size() > 0))) begin
                w = '0;
                foreach (mq[i]) w = (w << CODE_W) | BUF_W'(mq[i]);
                m_buf   = w;
                m_cnt   = CNT_W'(mq.size());
                m_valid = 1;
                mq.delete();
                m_pend  = 0;
            end else begin
                if (dct_ready) m_valid = 0;
                m_pend = fl && (mq.size() > 0);
            end
            if (drop)              m_ovf = 1;
            else if (overflow_clr) m_ovf = 0;
            if (overflow_clr)                    m_drops = drop ? 1 : 0;
            else if (drop && m_drops < 65535)    m_drops++;
        end
    end

    always @(negedge clk) begin
        chk("dct_valid", 32'(dct_valid), 32'(m_valid));
        if (m_valid || reset) begin
            chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
            chk("dct_count", 32'(dct_count), 32'(m_cnt));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
        chk("drop_count", 32'(drop_count), m_drops);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CODE_W-1:0] c, input bit f);
        code_valid = 1'b1;
        code       = c;
        flush      = f;
        tick();
        code_valid = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        trace_enable = 1'b1;
        dct_ready    = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(dct_valid), 32'd0);
        chk("rst_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_count", 32'(dct_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Full word of loads, one cycle latency
        for (int i = 0; i < 15; i++) send(CODE_LOAD, 0);
        chk("t1_valid", 32'(dct_valid), 32'd1);
        chk("t1_count", 32'(dct_count), 32'd15);
        chk("t1_buffer", 32'(dct_buffer), 32'h15555555);
        tick();
        chk("t1_drain", 32'(dct_valid), 32'd0);

        // Partial word via flush; a disabled-cycle code is ignored
        send(CODE_MARKER, 0);
        trace_enable = 1'b0;
        send(CODE_NONE, 0);
        trace_enable = 1'b1;
        send(CODE_STORE, 0);
        send(CODE_LOAD, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t2_count", 32'(dct_count), 32'd3);
        chk("t2_buffer", 32'(dct_buffer), 32'h39);
        tick();

        // Backpressure: held word, full accumulator, dropped code
        dct_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(CODE_STORE, 0);
        for (int i = 0; i < 15; i++) send(CODE_MARKER, 0);
        send(CODE_LOAD, 0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_held", 32'(dct_buffer), 32'h2AAAAAAA);
        dct_ready = 1'b1;
        tick();
        chk("t3_word2_valid", 32'(dct_valid), 32'd1);
        chk("t3_word2", 32'(dct_buffer), 32'h3FFFFFFF);
        tick();
        chk("t3_drain", 32'(dct_valid), 32'd0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // Flush coincident with completion; flush on empty accumulator
        for (int i = 0; i < 14; i++) send(CODE_LOAD, 0);
        send(CODE_STORE, 1);
        chk("t4_count", 32'(dct_count), 32'd15);
        chk("t4_buffer", 32'(dct_buffer), 32'h15555556);
        tick();
        chk("t4_no_extra", 32'(dct_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_empty_flush", 32'(dct_valid), 32'd0);
        tick();

        // Asynchronous reset while a word is held and another is filling
        dct_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(CODE_MARKER, 0);
        for (int i = 0; i < 3; i++) send(CODE_LOAD, 0);
        chk("t5_pre_valid", 32'(dct_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(dct_valid), 32'd0);
        chk("t5_async_buffer", 32'(dct_buffer), 32'd0);
        chk("t5_async_count", 32'(dct_count), 32'd0);
        tick();
        reset     = 1'b0;
        dct_ready = 1'b1;
        tick();
        send(CODE_STORE, 0);
        send(CODE_LOAD, 1);
        chk("t5_new_count", 32'(dct_count), 32'd2);
        chk("t5_new_buffer", 32'(dct_buffer), 32'h9);
        tick();

`ifdef NIOS2_OCI_DCT_DROPCNT_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        dct_ready = 1'b0;
        for (int i = 0; i < 30; i++) send(CODE_LOAD, 0);
        for (int i = 0; i < 300; i++) send(CODE_STORE, 0);
        chk("t6_drops", 32'(drop_count), 32'd300);
        overflow_clr = 1'b1;
        send(CODE_STORE, 0);
        chk("t6_clr_drop", 32'(drop_count), 32'd1);
        chk("t6_clr_ovf", 32'(overflow), 32'd1);
        tick();
        overflow_clr = 1'b0;
        chk("t6_clr_only", 32'(drop_count), 32'd0);
        chk("t6_clr_ovf0", 32'(overflow), 32'd0);
        dct_ready = 1'b1;
        repeat (3) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
